// File: rtl/pc_branch_unit.sv
// Program counter and branch-resolution unit with RUN/FLUSH/TRAP sequencing.
// Optional branch statistics counters are enabled by defining BRANCH_STATS_EN.
module pc_branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        inst_valid,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic        BrEq,
    input  logic        BrLT,
    output logic        BrUn,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic [31:0] pc,
    output logic        taken,
    output logic [31:0] target,
    output logic        flush,
    output logic        misalign_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] br_taken_count
`endif
);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_TRAP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        err_q, err_d;
    logic        cond_true;
    logic [31:0] jalr_sum;

    assign BrUn = is_branch & funct3[1];

    always_comb begin
        cond_true = 1'b0;
        case (funct3)
            3'b000:          cond_true = BrEq;
            3'b001:          cond_true = ~BrEq;
            3'b100, 3'b110:  cond_true = BrLT;
            3'b101, 3'b111:  cond_true = ~BrLT;
            default:         cond_true = 1'b0;
        endcase
    end

    always_comb begin
        jalr_sum = rs1 + imm;
        target   = pc_q + imm;
        if (!is_jal && is_jalr) begin
            target = {jalr_sum[31:1], 1'b0};
        end
        taken = (state_q == ST_RUN) && inst_valid &&
                (is_jal || is_jalr || (is_branch && cond_true));
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        if (rst) begin
            state_d = ST_RUN;
            pc_d    = RESET_PC;
            err_d   = 1'b0;
        end else if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    if (!taken) begin
                        pc_d = pc_q + 32'd4;
                    end else if (target[1:0] == 2'b00) begin
                        pc_d    = target;
                        state_d = ST_FLUSH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_TRAP;
                    end
                end
                ST_FLUSH: begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_TRAP;
                end
            endcase
        end
        flush_d = (state_d == ST_FLUSH);
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] br_taken_q, br_taken_d;
    logic        commit;

    // JAL/JALR outrank is_branch, so a simultaneous JAL is not a conditional branch take.
    always_comb begin
        commit     = !rst && !stall && (state_q == ST_RUN) && inst_valid;
        br_count_d = br_count_q;
        br_taken_d = br_taken_q;
        if (rst) begin
            br_count_d = '0;
            br_taken_d = '0;
        end else if (commit && is_branch) begin
            br_count_d = br_count_q + 32'd1;
            if (!is_jal && !is_jalr && cond_true) begin
                br_taken_d = br_taken_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        br_count_q <= br_count_d;
        br_taken_q <= br_taken_d;
    end

    assign br_count       = br_count_q;
    assign br_taken_count = br_taken_q;
`endif

    always_ff @(posedge clk) begin
        state_q <= state_d;
        pc_q    <= pc_d;
        flush_q <= flush_d;
        err_q   <= err_d;
    end

    assign pc           = pc_q;
    assign flush        = flush_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed vector table followed by
// randomized stimulus against a behavioural reference model.
module tb_pc_branch_unit;

    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, stall, inst_valid, is_branch, is_jal, is_jalr;
    logic [2:0]  funct3;
    logic        BrEq, BrLT, BrUn;
    logic [31:0] imm, rs1, pc, target;
    logic        taken, flush, misalign_err;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count, br_taken_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pc_branch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .inst_valid(inst_valid),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .funct3(funct3), .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn),
        .imm(imm), .rs1(rs1), .pc(pc), .taken(taken), .target(target),
        .flush(flush), .misalign_err(misalign_err)
`ifdef BRANCH_STATS_EN
        , .br_count(br_count), .br_taken_count(br_taken_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, valid, br, jal, jalr;
        logic [2:0]  f3;
        logic        eq, lt;
        logic [31:0] imm, rs1;
        logic        chk;
        logic [31:0] e_pc;
        logic        e_taken;
        logic [31:0] e_target;
        logic        e_flush, e_err, e_brun;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, s, v, b, j, jr, input logic [2:0] f,
                       input logic eq, lt, input logic [31:0] im, r1,
                       input logic c, input logic [31:0] epc, input logic etk,
                       input logic [31:0] etg, input logic efl, eer, ebu);
        vec_t x;
        x = '{r, s, v, b, j, jr, f, eq, lt, im, r1, c, epc, etk, etg, efl, eer, ebu};
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, s, v, b, j, jr, input logic [2:0] f,
                         input logic eq, lt, input logic [31:0] im, r1);
        rst = r; stall = s; inst_valid = v; is_branch = b; is_jal = j; is_jalr = jr;
        funct3 = f; BrEq = eq; BrLT = lt; imm = im; rs1 = r1;
    endtask

    // Reference model: 0 = running, 1 = flushing, 2 = trapped
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] m_brc, m_brtc;

    function automatic logic cond_of(input logic [2:0] f, input logic eq, lt);
        if (f == 3'd0) return eq;
        if (f == 3'd1) return !eq;
        if (f == 3'd4 || f == 3'd6) return lt;
        if (f == 3'd5 || f == 3'd7) return !lt;
        return 1'b0;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        e_tk;
        logic [31:0] e_tg, sum;
        logic        r, s, v, b, j, jr, eq, lt;
        logic [2:0]  f;
        logic [31:0] im, r1;

        // rst rst | idle x3 | JAL->FC | flush | BEQ | flush | BGEU/011/010 | stall x3 | release ...
        add(1,0,0,0,0,0,0,0,0, 0,0, 0, 0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0, 0,0, 1, 32'h1000,0,32'h1000,0,0,0);
        add(0,0,0,0,0,0,0,0,0, 0,0, 1, 32'h1000,0,32'h1000,0,0,0);
        add(0,0,0,0,0,0,0,0,0, 0,0, 1, 32'h1004,0,32'h1004,0,0,0);
        add(0,0,0,0,0,0,0,0,0, 0,0, 1, 32'h1008,0,32'h1008,0,0,0);
        add(0,0,1,0,1,0,0,0,0, 32'hFFFF_F0F0,0, 1, 32'h100C,1,32'h00FC,0,0,0);
        add(0,0,0,0,0,0,0,0,0, 0,0, 1, 32'h00FC,0,32'h00FC,1,0,0);
        add(0,0,1,1,0,0,0,1,0, 32'h20,0, 1, 32'h0100,1,32'h0120,0,0,0);
        add(0,0,1,1,1,0,0,1,0, 0,0, 1, 32'h0120,0,32'h0120,1,0,0);
        add(0,0,1,1,0,0,7,0,1, 32'h40,0, 1, 32'h0124,0,32'h0164,0,0,1);
        add(0,0,1,1,0,0,3,1,1, 32'h8,0, 1, 32'h0128,0,32'h0130,0,0,1);
        add(0,0,1,1,0,0,2,1,0, 0,0, 1, 32'h012C,0,32'h012C,0,0,1);
        add(0,1,1,1,0,0,0,1,0, 32'h10,0, 1, 32'h0130,1,32'h0140,0,0,0);
        add(0,1,1,1,0,0,0,1,0, 32'h10,0, 1, 32'h0130,1,32'h0140,0,0,0);
        add(0,1,1,1,0,0,0,1,0, 32'h10,0, 1, 32'h0130,1,32'h0140,0,0,0);
        add(0,0,1,1,0,0,0,1,0, 32'h10,0, 1, 32'h0130,1,32'h0140,0,0,0);
        add(0,0,0,0,0,0,0,0,0, 0,0, 1, 32'h0140,0,32'h0140,1,0,0);
        add(0,0,1,1,1,0,0,0,0, 32'h8,0, 1, 32'h0144,1,32'h014C,0,0,0);
        add(0,0,0,0,0,0,0,0,0, 0,0, 1, 32'h014C,0,32'h014C,1,0,0);
        add(0,0,1,0,1,0,0,0,0, 32'hFFFF_FEA8,0, 1, 32'h0150,1,32'hFFFF_FFF8,0,0,0);
        add(0,0,0,0,0,0,0,0,0, 0,0, 1, 32'hFFFF_FFF8,0,32'hFFFF_FFF8,1,0,0);
        add(0,0,0,0,0,0,0,0,0, 0,0, 1, 32'hFFFF_FFFC,0,32'hFFFF_FFFC,0,0,0);
        add(0,0,0,0,0,0,0,0,0, 0,0, 1, 32'h0000_0000,0,32'h0000_0000,0,0,0);
        add(0,0,1,0,0,1,0,0,0, 32'h4,32'h203, 1, 32'h0004,1,32'h0206,0,0,0);
        add(0,0,1,0,1,0,0,0,0, 32'h10,0, 1, 32'h0004,0,32'h0014,0,1,0);
        add(0,0,0,0,0,0,0,0,0, 0,0, 1, 32'h0004,0,32'h0004,0,1,0);
        add(1,0,0,0,0,0,0,0,0, 0,0, 1, 32'h0004,0,32'h0004,0,1,0);
        add(0,0,0,0,0,0,0,0,0, 0,0, 1, 32'h1000,0,32'h1000,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].valid, vecs[i].br, vecs[i].jal,
                  vecs[i].jalr, vecs[i].f3, vecs[i].eq, vecs[i].lt, vecs[i].imm, vecs[i].rs1);
            #1;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
                check($sformatf("vec%0d_taken", i), {31'b0, taken}, {31'b0, vecs[i].e_taken});
                check($sformatf("vec%0d_target", i), target, vecs[i].e_target);
                check($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].e_flush});
                check($sformatf("vec%0d_err", i), {31'b0, misalign_err}, {31'b0, vecs[i].e_err});
                check($sformatf("vec%0d_brun", i), {31'b0, BrUn}, {31'b0, vecs[i].e_brun});
            end
            @(posedge clk);
            #1;
        end

        // Randomized phase: first cycle resets both DUT and model.
        for (int n = 0; n < 600; n++) begin
            r  = (n == 0) || ($urandom_range(0, 29) == 0);
            s  = ($urandom_range(0, 4) == 0);
            v  = ($urandom_range(0, 3) != 0);
            b  = ($urandom_range(0, 1) == 1);
            j  = ($urandom_range(0, 5) == 0);
            jr = ($urandom_range(0, 5) == 0);
            f  = 3'($urandom_range(0, 7));
            eq = 1'($urandom_range(0, 1));
            lt = 1'($urandom_range(0, 1));
            im = ($urandom_range(0, 9) == 0) ? 32'($urandom) : (32'($urandom_range(0, 255)) << 2) - 32'd512;
            r1 = ($urandom_range(0, 1) == 1) ? (32'($urandom) & ~32'h2) : 32'($urandom);
            drive(r, s, v, b, j, jr, f, eq, lt, im, r1);
            #1;
            if (n != 0) begin
                if (j) e_tg = m_pc + im;
                else if (jr) begin sum = r1 + im; e_tg = {sum[31:1], 1'b0}; end
                else e_tg = m_pc + im;
                e_tk = (m_mode == 0) && v && (j || jr || (b && cond_of(f, eq, lt)));
                check("rnd_pc", pc, m_pc);
                check("rnd_taken", {31'b0, taken}, {31'b0, e_tk});
                check("rnd_target", target, e_tg);
                check("rnd_flush", {31'b0, flush}, {31'b0, (m_mode == 1)});
                check("rnd_err", {31'b0, misalign_err}, {31'b0, m_err});
                check("rnd_brun", {31'b0, BrUn}, {31'b0, b & f[1]});
`ifdef BRANCH_STATS_EN
                check("rnd_br_count", br_count, m_brc);
                check("rnd_br_taken_count", br_taken_count, m_brtc);
`endif
            end else begin
                e_tk = 1'b0; e_tg = '0;
            end
            if (r) begin
                m_pc = RPC; m_mode = 0; m_err = 1'b0; m_brc = '0; m_brtc = '0;
            end else if (!s) begin
                if (m_mode == 0 && v && b) begin
                    m_brc = m_brc + 1;
                    if (!j && !jr && cond_of(f, eq, lt)) m_brtc = m_brtc + 1;
                end
                if (m_mode == 1) begin
                    m_pc = m_pc + 4; m_mode = 0;
                end else if (m_mode == 0) begin
                    if (!e_tk) m_pc = m_pc + 4;
                    else if (e_tg[1:0] == 2'b00) begin m_pc = e_tg; m_mode = 1; end
                    else begin m_err = 1'b1; m_mode = 2; end
                end
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
